// File: rtl/contact_resolve_sequencer_if.sv
// Bus bundle between the contact resolve sequencer and its environment:
// contact FIFO, body-state RAM, combinational resolver and status.
interface contact_resolve_sequencer_if #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned BODY_W = 192,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned GEOM_W = 100;
  localparam int unsigned IMP_W  = 103;

  logic              ctc_valid;
  logic              ctc_ready;
  logic [IDX_W-1:0]  ctc_idx_a;
  logic [IDX_W-1:0]  ctc_idx_b;
  logic [GEOM_W-1:0] ctc_geom;
  logic [IDX_W-1:0]  bmem_raddr;
  logic [BODY_W-1:0] bmem_rdata;
  logic              bmem_we;
  logic [IDX_W-1:0]  bmem_waddr;
  logic [BODY_W-1:0] bmem_wdata;
  logic [BODY_W-1:0] obb1_rec;
  logic [BODY_W-1:0] obb2_rec;
  logic [GEOM_W-1:0] res_geom;
  logic [IMP_W-1:0]  res_imp1;
  logic [IMP_W-1:0]  res_imp2;
  logic              res_ignore;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  resolved_cnt;
  logic [CNT_W-1:0]  dropped_cnt;

  modport master (
    input  ctc_valid, ctc_idx_a, ctc_idx_b, ctc_geom, bmem_rdata,
           res_imp1, res_imp2, res_ignore,
    output ctc_ready, bmem_raddr, bmem_we, bmem_waddr, bmem_wdata,
           obb1_rec, obb2_rec, res_geom, busy, done, resolved_cnt, dropped_cnt
  );

  modport slave (
    output ctc_valid, ctc_idx_a, ctc_idx_b, ctc_geom, bmem_rdata,
           res_imp1, res_imp2, res_ignore,
    input  ctc_ready, bmem_raddr, bmem_we, bmem_waddr, bmem_wdata,
           obb1_rec, obb2_rec, res_geom, busy, done, resolved_cnt, dropped_cnt
  );
endinterface

// File: rtl/contact_resolve_sequencer.sv
// Drains contacts one at a time: fetches both bodies, presents them to the
// OBB-OBB resolver, then writes back saturated vel/pos/omega updates.
module contact_resolve_sequencer #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned BODY_W = 192,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  contact_resolve_sequencer_if.master bus
);
  localparam int unsigned GEOM_W = 100;
  localparam int unsigned IMP_W  = 103;

  typedef enum logic [2:0] {
    S_IDLE, S_DROP, S_RD_A, S_RD_B, S_CAP_B, S_RES, S_WR_A, S_WR_B
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  a_q, a_d, b_q, b_d;
  logic [GEOM_W-1:0] geom_q, geom_d;
  logic [BODY_W-1:0] obb1_q, obb1_d, obb2_q, obb2_d;
  logic [IMP_W-1:0]  imp2_q, imp2_d;
  logic              ign_q, ign_d;
  logic [IDX_W-1:0]  raddr_q, raddr_d, waddr_q, waddr_d;
  logic [BODY_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d, done_q, done_d, ready_q, ready_d, busy_q, busy_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d, dcnt_q, dcnt_d;

  function automatic logic [23:0] sat_add24(input logic [23:0] x, input logic [23:0] y);
    logic [24:0] s;
    s = {x[23], x} + {y[23], y};
    if (s[24] != s[23]) return s[24] ? 24'h800000 : 24'h7FFFFF;
    return s[23:0];
  endfunction

  function automatic logic [10:0] sat_add11(input logic [10:0] x, input logic [10:0] y);
    logic [11:0] s;
    s = {x[10], x} + {y[10], y};
    if (s[11] != s[10]) return s[11] ? 11'h400 : 11'h3FF;
    return s[10:0];
  endfunction

  // Nudge is in quarter units of position: widen to 26 bits, then clamp.
  function automatic logic [23:0] sat_pos(input logic [23:0] p, input logic [21:0] n);
    logic [25:0] s;
    s = {{2{p[23]}}, p} + {{2{n[21]}}, n, 2'b00};
    if (s[25:23] != 3'b000 && s[25:23] != 3'b111) return s[25] ? 24'h800000 : 24'h7FFFFF;
    return s[23:0];
  endfunction

  function automatic logic [BODY_W-1:0] update_rec(input logic [BODY_W-1:0] rec,
                                                   input logic [IMP_W-1:0]  imp,
                                                   input logic              ign);
    logic [BODY_W-1:0] r;
    r          = rec;
    r[117:94]  = sat_pos(rec[117:94], imp[54:33]);
    r[93:70]   = sat_pos(rec[93:70], imp[32:11]);
    if (!ign) begin
      r[69:46] = sat_add24(rec[69:46], imp[102:79]);
      r[45:22] = sat_add24(rec[45:22], imp[78:55]);
      r[10:0]  = sat_add11(rec[10:0], imp[10:0]);
    end
    return r;
  endfunction

  // State register and all datapath flops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      geom_q  <= '0;
      obb1_q  <= '0;
      obb2_q  <= '0;
      imp2_q  <= '0;
      ign_q   <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      geom_q  <= geom_d;
      obb1_q  <= obb1_d;
      obb2_q  <= obb2_d;
      imp2_q  <= imp2_d;
      ign_q   <= ign_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      rcnt_q  <= rcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state and registered-output logic; outputs line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    geom_d  = geom_q;
    obb1_d  = obb1_q;
    obb2_d  = obb2_q;
    imp2_d  = imp2_q;
    ign_d   = ign_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    rcnt_d  = rcnt_q;
    dcnt_d  = dcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ctc_valid && ready_q) begin
          a_d    = bus.ctc_idx_a;
          b_d    = bus.ctc_idx_b;
          geom_d = bus.ctc_geom;
          if (bus.ctc_idx_a == bus.ctc_idx_b) begin
            state_d = S_DROP;
          end else begin
            raddr_d = bus.ctc_idx_a;
            state_d = S_RD_A;
          end
        end
      end
      S_DROP: begin
        dcnt_d  = dcnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      S_RD_A: begin
        raddr_d = b_q;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        obb1_d  = bus.bmem_rdata;
        state_d = S_CAP_B;
      end
      S_CAP_B: begin
        obb2_d  = bus.bmem_rdata;
        state_d = S_RES;
      end
      // Body A writeback is formed from the settled resolver outputs directly.
      S_RES: begin
        imp2_d  = bus.res_imp2;
        ign_d   = bus.res_ignore;
        waddr_d = a_q;
        wdata_d = update_rec(obb1_q, bus.res_imp1, bus.res_ignore);
        we_d    = |obb1_q[159:143];
        state_d = S_WR_A;
      end
      S_WR_A: begin
        waddr_d = b_q;
        wdata_d = update_rec(obb2_q, imp2_q, ign_q);
        we_d    = |obb2_q[159:143];
        state_d = S_WR_B;
      end
      S_WR_B: begin
        if (!ign_q) rcnt_d = rcnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DROP) || (state_d == S_WR_B);
  end

  assign bus.ctc_ready    = ready_q;
  assign bus.bmem_raddr   = raddr_q;
  assign bus.bmem_we      = we_q;
  assign bus.bmem_waddr   = waddr_q;
  assign bus.bmem_wdata   = wdata_q;
  assign bus.obb1_rec     = obb1_q;
  assign bus.obb2_rec     = obb2_q;
  assign bus.res_geom     = geom_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.resolved_cnt = rcnt_q;
  assign bus.dropped_cnt  = dcnt_q;
endmodule

// File: tb/tb_contact_resolve_sequencer.sv
// Directed bench: behavioural sync body RAM, table of contact vectors with
// hand-computed writeback records, plus reset and back-to-back sequences.
module tb_contact_resolve_sequencer;
  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  contact_resolve_sequencer_if #(.IDX_W(6), .BODY_W(192), .CNT_W(16)) bus ();
  contact_resolve_sequencer #(.IDX_W(6), .BODY_W(192), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [191:0] mem [64];
  logic         ld_en = 1'b0;
  logic [5:0]   ld_addr = '0;
  logic [191:0] ld_data = '0;
  logic [5:0]   wr_log[$];

  // Sync-read body RAM; bench preload has priority over DUT writes.
  always @(posedge Clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.bmem_we) mem[bus.bmem_waddr] <= bus.bmem_wdata;
    bus.bmem_rdata <= mem[bus.bmem_raddr];
    if (bus.bmem_we) wr_log.push_back(bus.bmem_waddr);
  end

  function automatic logic [191:0] mk_rec(input logic [16:0] im, input logic [23:0] px,
      input logic [23:0] py, input logic [23:0] vx, input logic [23:0] vy, input logic [10:0] om);
    return {8'h11, 8'h22, 16'h3333, im, 25'h0ABCDE, px, py, vx, vy, 11'h155, om};
  endfunction

  function automatic logic [102:0] mk_imp(input logic [23:0] ix, input logic [23:0] iy,
      input logic [21:0] nx, input logic [21:0] ny, input logic [10:0] rot);
    return {ix, iy, nx, ny, rot};
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [191:0] d);
    @(negedge Clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge Clk);
    ld_en = 1'b0;
  endtask

  // Returns accept-edge to done-edge count inclusive, or -1 on timeout.
  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [99:0] g,
                      output int cyc);
    int  guard;
    bit  hit;
    @(negedge Clk);
    bus.ctc_valid = 1'b1; bus.ctc_idx_a = a; bus.ctc_idx_b = b; bus.ctc_geom = g;
    guard = 0;
    while (!bus.ctc_ready && guard < 20) begin @(negedge Clk); guard++; end
    @(posedge Clk);
    cyc = 1; hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge Clk);
      bus.ctc_valid = 1'b0;
      if (bus.done) hit = 1'b1;
      else begin @(posedge Clk); cyc++; end
    end
    if (hit) begin
      cyc++;
      @(posedge Clk);
      @(negedge Clk);
    end else cyc = -1;
  endtask

  typedef struct {
    logic [5:0]   a, b;
    logic         ign;
    logic [102:0] imp1, imp2;
    logic [191:0] rec_a, rec_b, exp_a, exp_b;
    int           writes;
  } vec_t;

  vec_t vecs[5];
  int   exp_res = 0;
  int   exp_drop = 0;

  initial begin
    int cyc;
    int n0;
    logic [99:0] g;
    logic [191:0] r1, r2, r4;

    vecs[0] = '{6'd3, 6'd5, 1'b0,
      mk_imp(24'h000100, 24'h0, 22'h0, 22'h0, 11'h0),
      mk_imp(24'h0, 24'hFFFFF0, 22'h0, 22'h0, 11'h0),
      mk_rec(17'h1, 24'h001000, 24'h002000, 24'h000200, 24'h0, 11'h000),
      mk_rec(17'h2, 24'h003000, 24'h004000, 24'h0, 24'h000050, 11'h001),
      mk_rec(17'h1, 24'h001000, 24'h002000, 24'h000300, 24'h0, 11'h000),
      mk_rec(17'h2, 24'h003000, 24'h004000, 24'h0, 24'h000040, 11'h001), 2};
    vecs[1] = '{6'd10, 6'd11, 1'b0,
      mk_imp(24'h000100, 24'h0, 22'h0, 22'h0, 11'h020),
      mk_imp(24'hFFFF00, 24'h0, 22'h0, 22'h0, 11'h7E0),
      mk_rec(17'h5, 24'h0, 24'h0, 24'h7FFFF0, 24'h0, 11'h3F0),
      mk_rec(17'h6, 24'h0, 24'h0, 24'h800010, 24'h0, 11'h410),
      mk_rec(17'h5, 24'h0, 24'h0, 24'h7FFFFF, 24'h0, 11'h3FF),
      mk_rec(17'h6, 24'h0, 24'h0, 24'h800000, 24'h0, 11'h400), 2};
    vecs[2] = '{6'd12, 6'd13, 1'b1,
      mk_imp(24'h000100, 24'h0, 22'h000004, 22'h0, 11'h005),
      mk_imp(24'h000100, 24'h000100, 22'h0, 22'h3FFFFF, 11'h001),
      mk_rec(17'h1, 24'h000100, 24'h0, 24'h000050, 24'h0, 11'h010),
      mk_rec(17'h1, 24'h0, 24'h000010, 24'h0, 24'h000020, 11'h002),
      mk_rec(17'h1, 24'h000110, 24'h0, 24'h000050, 24'h0, 11'h010),
      mk_rec(17'h1, 24'h0, 24'h00000C, 24'h0, 24'h000020, 11'h002), 2};
    vecs[3] = '{6'd14, 6'd15, 1'b0,
      mk_imp(24'h0, 24'h0, 22'h000100, 22'h200000, 11'h0),
      mk_imp(24'h000100, 24'h0, 22'h000010, 22'h0, 11'h001),
      mk_rec(17'h3, 24'h7FFFF0, 24'hFFFFF0, 24'h000007, 24'h0, 11'h0),
      mk_rec(17'h0, 24'h000100, 24'h0, 24'h000100, 24'h0, 11'h0),
      mk_rec(17'h3, 24'h7FFFFF, 24'h800000, 24'h000007, 24'h0, 11'h0),
      mk_rec(17'h0, 24'h000100, 24'h0, 24'h000100, 24'h0, 11'h0), 1};
    vecs[4] = '{6'd7, 6'd7, 1'b0,
      mk_imp(24'h000100, 24'h0, 22'h0, 22'h0, 11'h0),
      mk_imp(24'h000100, 24'h0, 22'h0, 22'h0, 11'h0),
      mk_rec(17'h1, 24'h0, 24'h0, 24'h000200, 24'h0, 11'h0),
      '0,
      mk_rec(17'h1, 24'h0, 24'h0, 24'h000200, 24'h0, 11'h0),
      '0, 0};

    // Reset with a contact pending.
    Reset_n = 1'b0;
    bus.ctc_valid = 1'b1; bus.ctc_idx_a = 6'd1; bus.ctc_idx_b = 6'd2; bus.ctc_geom = '0;
    bus.res_imp1 = '0; bus.res_imp2 = '0; bus.res_ignore = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_ready", 192'(bus.ctc_ready), 192'(0));
    check("rst_we", 192'(bus.bmem_we), 192'(0));
    check("rst_busy", 192'(bus.busy), 192'(0));
    check("rst_done", 192'(bus.done), 192'(0));
    check("rst_cnts", 192'({bus.resolved_cnt, bus.dropped_cnt}), 192'(0));
    bus.ctc_valid = 1'b0;
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rel_ready", 192'(bus.ctc_ready), 192'(1));

    foreach (vecs[i]) begin
      preload(vecs[i].a, vecs[i].rec_a);
      if (vecs[i].a != vecs[i].b) preload(vecs[i].b, vecs[i].rec_b);
      bus.res_imp1 = vecs[i].imp1; bus.res_imp2 = vecs[i].imp2; bus.res_ignore = vecs[i].ign;
      g = {4'h9, 96'(i) * 96'h0123_4567_89AB};
      n0 = wr_log.size();
      send(vecs[i].a, vecs[i].b, g, cyc);
      check($sformatf("v%0d_cycles", i), 192'(cyc), 192'((vecs[i].a == vecs[i].b) ? 2 : 7));
      check($sformatf("v%0d_writes", i), 192'(wr_log.size() - n0), 192'(vecs[i].writes));
      if (wr_log.size() > n0) check($sformatf("v%0d_waddr0", i), 192'(wr_log[n0]), 192'(vecs[i].a));
      check($sformatf("v%0d_mem_a", i), mem[vecs[i].a], vecs[i].exp_a);
      check($sformatf("v%0d_geom", i), 192'(bus.res_geom), 192'(g));
      if (vecs[i].a != vecs[i].b) begin
        check($sformatf("v%0d_mem_b", i), mem[vecs[i].b], vecs[i].exp_b);
        check($sformatf("v%0d_obb1", i), bus.obb1_rec, vecs[i].rec_a);
        check($sformatf("v%0d_obb2", i), bus.obb2_rec, vecs[i].rec_b);
        if (!vecs[i].ign) exp_res++;
      end else exp_drop++;
      check($sformatf("v%0d_resolved", i), 192'(bus.resolved_cnt), 192'(exp_res));
      check($sformatf("v%0d_dropped", i), 192'(bus.dropped_cnt), 192'(exp_drop));
      check($sformatf("v%0d_idle", i), 192'({bus.busy, bus.done, bus.ctc_ready}), 192'(3'b001));
    end

    // Back-to-back contacts sharing body 2.
    r1 = mk_rec(17'h1, 24'h0, 24'h0, 24'h000100, 24'h0, 11'h0);
    r2 = mk_rec(17'h1, 24'h0, 24'h0, 24'h000200, 24'h0, 11'h0);
    r4 = mk_rec(17'h1, 24'h0, 24'h0, 24'h000400, 24'h0, 11'h0);
    preload(6'd1, r1); preload(6'd2, r2); preload(6'd4, r4);
    bus.res_imp1 = mk_imp(24'h000010, 24'h0, 22'h0, 22'h0, 11'h0);
    bus.res_imp2 = mk_imp(24'h000020, 24'h0, 22'h0, 22'h0, 11'h0);
    bus.res_ignore = 1'b0;
    send(6'd1, 6'd2, '0, cyc);
    check("b2b_c1_cycles", 192'(cyc), 192'(7));
    send(6'd2, 6'd4, '0, cyc);
    check("b2b_c2_cycles", 192'(cyc), 192'(7));
    check("b2b_obb1", bus.obb1_rec, mk_rec(17'h1, 24'h0, 24'h0, 24'h000220, 24'h0, 11'h0));
    check("b2b_mem1", mem[1], mk_rec(17'h1, 24'h0, 24'h0, 24'h000110, 24'h0, 11'h0));
    check("b2b_mem2", mem[2], mk_rec(17'h1, 24'h0, 24'h0, 24'h000230, 24'h0, 11'h0));
    check("b2b_mem4", mem[4], mk_rec(17'h1, 24'h0, 24'h0, 24'h000420, 24'h0, 11'h0));
    check("b2b_resolved", 192'(bus.resolved_cnt), 192'(exp_res + 2));

    // Reset pulsed while the resolver is settling.
    r1 = mk_rec(17'h1, 24'h0, 24'h0, 24'h000300, 24'h0, 11'h0);
    preload(6'd20, r1); preload(6'd21, r1);
    n0 = wr_log.size();
    @(negedge Clk);
    bus.ctc_valid = 1'b1; bus.ctc_idx_a = 6'd20; bus.ctc_idx_b = 6'd21;
    @(posedge Clk);
    @(negedge Clk); bus.ctc_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check("res_busy", 192'(bus.busy), 192'(1));
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("res_rst_idle", 192'({bus.busy, bus.bmem_we, bus.done}), 192'(0));
    Reset_n = 1'b1;
    @(negedge Clk);
    check("res_ready", 192'(bus.ctc_ready), 192'(1));
    repeat (3) @(negedge Clk);
    check("res_no_write", 192'(wr_log.size() - n0), 192'(0));
    check("res_mem20", mem[20], r1);
    check("res_cnt", 192'(bus.resolved_cnt), 192'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
